// File: rtl/fact_initiator.sv
// rtl/fact_initiator.sv - start/done handshake initiator for the factorial core
// Optional build macro FACT_OVF_SKIP_EN: operands above MAX_ARG bypass the core
// and complete immediately with a zero result and res_ovf set.
module fact_initiator #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int MAX_ARG = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              res_timeout,
    output logic              f_start,
    output logic [DATA_W-1:0] f_data,
    input  logic              f_done,
    input  logic [RES_W-1:0]  f_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ARG_MAX  = DATA_W'(MAX_ARG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // Single control FSM; every output is a register so nothing is combinational from inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ovf         <= 1'b0;
            op_ready    <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_ovf     <= 1'b0;
            res_timeout <= 1'b0;
            f_start     <= 1'b0;
            f_data      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        op_ready <= 1'b0;
`ifdef FACT_OVF_SKIP_EN
                        if (op_data > ARG_MAX) begin
                            // Result cannot fit: finish without bothering the core.
                            res_data    <= '0;
                            res_ovf     <= 1'b1;
                            res_timeout <= 1'b0;
                            res_valid   <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            f_data  <= op_data;
                            ovf     <= 1'b0;
                            f_start <= 1'b1;
                            state   <= S_START;
                        end
`else
                        f_data  <= op_data;
                        ovf     <= (op_data > ARG_MAX);
                        f_start <= 1'b1;
                        state   <= S_START;
`endif
                    end
                end
                S_START: begin
                    // f_start was raised on entry, so this state lasts exactly one pulse.
                    f_start <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (f_done) begin
                        // done has priority over a timeout expiring in the same cycle
                        res_data    <= f_result;
                        res_ovf     <= ovf;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        res_data    <= '0;
                        res_ovf     <= ovf;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Absorb a done that is still high, including one arriving after a timeout.
                    if (!f_done) begin
                        op_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    op_ready <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_initiator.sv
// tb/tb_fact_initiator.sv - randomized self-checking bench for fact_initiator
module tb_fact_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        res_timeout;
    logic        f_start;
    logic [7:0]  f_data;
    logic        f_done;
    logic [15:0] f_result;

    fact_initiator #(
        .DATA_W(8), .RES_W(16), .MAX_ARG(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_timeout(res_timeout),
        .f_start(f_start), .f_data(f_data), .f_done(f_done), .f_result(f_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [17:0] expq[$];
    int          mode_q[$];
    int          rdy_mode = 2;
    int          start_cnt = 0;
    int          start_cyc = 0;
    logic        prev_start = 1'b0;
    logic [17:0] held;
    bit          held_ok = 1'b0;
    logic [17:0] exp_entry;
    int          core_lat;
    logic [7:0]  core_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // n! truncated to 16 bits
    function automatic logic [15:0] ref_fact(input int n);
        int r = 1;
        for (int i = 2; i <= n; i++) r = (r * i) & 32'hFFFF;
        return r[15:0];
    endfunction

    // Expected {res_data, res_ovf, res_timeout} for one operand
    function automatic logic [17:0] expect_for(input int n, input bit hang);
        bit ovf = (n > 8);
`ifdef FACT_OVF_SKIP_EN
        if (ovf) return {16'h0, 1'b1, 1'b0};
`endif
        if (hang) return {16'h0, ovf, 1'b1};
        return {ref_fact(n), ovf, 1'b0};
    endfunction

    task automatic send_op(input int n, input bit hang, input int lat);
        bit ok = 1'b0;
        bit to_core = 1'b1;
`ifdef FACT_OVF_SKIP_EN
        to_core = (n <= 8);
`endif
        op_data  = 8'(n);
        op_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (op_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 32'd1);
        if (ok) begin
            expq.push_back(expect_for(n, hang));
            if (to_core) mode_q.push_back(hang ? -1 : lat);
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && expq.size() > 0; i++) @(negedge clk);
        check("drain", 32'(expq.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("res_valid_wait", 32'(ok), 32'd1);
    endtask

    // Core model: answers each start after a chosen latency, or never (hang)
    initial begin
        f_done   = 1'b0;
        f_result = 16'h0;
        forever begin
            @(negedge clk);
            if (f_start === 1'b1 && reset === 1'b0) begin
                core_n = f_data;
                check("core_mode_q", 32'(mode_q.size() > 0), 32'd1);
                if (mode_q.size() > 0) begin
                    core_lat = mode_q.pop_front();
                    if (core_lat >= 0) begin
                        repeat (core_lat) begin
                            @(negedge clk);
                            check("f_data_stable", 32'(f_data), 32'(core_n));
                        end
                        f_done   = 1'b1;
                        f_result = ref_fact(int'(core_n));
                        repeat ($urandom_range(1, 3)) @(negedge clk);
                        f_done   = 1'b0;
                        f_result = 16'($urandom);
                    end
                end
            end
        end
    end

    // Start-pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (f_start === 1'b1) begin
                check("start_single", 32'(prev_start), 32'd0);
                start_cnt++;
                start_cyc = cyc;
            end
            prev_start = f_start;
        end
    end

    // Result sink: drives res_ready and scores each handshake
    initial begin
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       res_ready = 1'($urandom_range(0, 1));
                1:       res_ready = 1'b0;
                default: res_ready = 1'b1;
            endcase
            if (res_valid === 1'b1 && held_ok)
                check("hold_stable", 32'({res_data, res_ovf, res_timeout}), 32'(held));
            if (res_valid === 1'b1 && res_ready) begin
                check("res_pending", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    exp_entry = expq.pop_front();
                    check("res_data", 32'(res_data), 32'(exp_entry[17:2]));
                    check("res_ovf", 32'(res_ovf), 32'(exp_entry[1]));
                    check("res_timeout", 32'(res_timeout), 32'(exp_entry[0]));
                end
                held_ok = 1'b0;
            end else if (res_valid === 1'b1) begin
                held    = {res_data, res_ovf, res_timeout};
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit hang;
        int n;

        // Reset held for three cycles with an operand offered
        reset    = 1'b1;
        op_valid = 1'b1;
        op_data  = 8'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_op_ready", 32'(op_ready), 32'd0);
            check("rst_f_start", 32'(f_start), 32'd0);
            check("rst_res_valid", 32'(res_valid), 32'd0);
        end
        reset    = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("post_rst_op_ready", 32'(op_ready), 32'd1);
        check("post_rst_res_data", 32'(res_data), 32'd0);
        check("post_rst_f_data", 32'(f_data), 32'd0);
        check("post_rst_flags", 32'({res_ovf, res_timeout}), 32'd0);

        // Operand 5, core answers after 6 cycles
        s0 = start_cnt;
        send_op(5, 1'b0, 6);
        drain();
        check("op5_starts", 32'(start_cnt - s0), 32'd1);

        // Operand 10 overflows the result width
        s0 = start_cnt;
        send_op(10, 1'b0, 3);
        drain();
`ifdef FACT_OVF_SKIP_EN
        check("op10_starts", 32'(start_cnt - s0), 32'd0);
`else
        check("op10_starts", 32'(start_cnt - s0), 32'd1);
`endif

        // Back-to-back 5 then 3 with the first result held off for 4 cycles
        s0 = start_cnt;
        rdy_mode = 1;
        fork
            begin
                send_op(5, 1'b0, 2);
                send_op(3, 1'b0, 4);
            end
            begin
                wait_valid();
                for (int i = 0; i < 4; i++) begin
                    check("b2b_hold_valid", 32'(res_valid), 32'd1);
                    check("b2b_hold_data", 32'(res_data), 32'h0078);
                    check("b2b_one_start", 32'(start_cnt - s0), 32'd1);
                    @(negedge clk);
                end
                rdy_mode = 2;
            end
        join
        drain();
        check("b2b_starts", 32'(start_cnt - s0), 32'd2);

        // Core never answers: timeout, then a late done is absorbed
        rdy_mode = 1;
        send_op(7, 1'b1, -1);
        wait_valid();
        check("timeout_latency", 32'(cyc - start_cyc), 32'd17);
        f_done   = 1'b1;
        f_result = 16'h1234;
        rdy_mode = 2;
        repeat (4) @(negedge clk);
        check("release_hold", 32'(op_ready), 32'd0);
        check("late_done_no_res", 32'(res_valid), 32'd0);
        f_done = 1'b0;
        repeat (2) @(negedge clk);
        check("release_exit", 32'(op_ready), 32'd1);
        send_op(4, 1'b0, 3);
        drain();

        // Reset in the middle of WAIT
        send_op(6, 1'b1, -1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        expq.delete();
        mode_q.delete();
        @(negedge clk);
        check("rw_outputs", 32'({op_ready, f_start, res_valid, res_ovf, res_timeout}), 32'd0);
        check("rw_f_data", 32'(f_data), 32'd0);
        check("rw_res_data", 32'(res_data), 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in the middle of HOLD
        rdy_mode = 1;
        send_op(2, 1'b0, 2);
        wait_valid();
        reset = 1'b1;
        expq.delete();
        mode_q.delete();
        @(negedge clk);
        check("rh_res_valid", 32'(res_valid), 32'd0);
        check("rh_res_data", 32'(res_data), 32'd0);
        check("rh_op_ready", 32'(op_ready), 32'd0);
        reset    = 1'b0;
        rdy_mode = 2;
        repeat (5) @(negedge clk);
        send_op(4, 1'b0, 4);
        drain();

        // Randomized traffic with random backpressure and occasional hung core
        rdy_mode = 0;
        for (int k = 0; k < 40; k++) begin
            n    = int'($urandom_range(0, 12));
            hang = ($urandom_range(0, 7) == 0);
            send_op(n, hang, hang ? -1 : int'($urandom_range(1, 10)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
